// File: rtl/lag_sweep_sequencer.sv
// Frame-level lag sweep controller: runs one integration frame per lag step,
// drives per-channel lag values and hands each finished frame to the TX path.
module lag_sweep_sequencer #(
    parameter int unsigned NUM_INPUTS  = 8,
    parameter int unsigned LAG_WIDTH   = 20,
    parameter int unsigned INC_WIDTH   = 12,
    parameter int unsigned FRAME_WIDTH = 24,
    parameter int unsigned IDX_WIDTH   = 12
) (
    input  logic                            intclk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            start,
    input  logic                            abort,
    input  logic [FRAME_WIDTH-1:0]          frame_cycles,
    input  logic [LAG_WIDTH-1:0]            lag_start,
    input  logic [LAG_WIDTH-1:0]            lag_len,
    input  logic [INC_WIDTH-1:0]            lag_inc,
    input  logic [NUM_INPUTS-1:0]           chan_mask,
    input  logic                            tx_ack,
    output logic                            integrate,
    output logic                            capture_start,
    output logic                            tx_req,
    output logic                            busy,
    output logic                            done,
    output logic [NUM_INPUTS*LAG_WIDTH-1:0] lag_current_a,
    output logic [IDX_WIDTH-1:0]            frame_idx
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        INTEGRATE,
        TX_WAIT,
        STEP,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [FRAME_WIDTH-1:0] frame_load, frame_init, frame_cnt;
    logic [LAG_WIDTH-1:0]   sh_start, sh_len, cur_lag;
    logic [INC_WIDTH-1:0]   sh_inc;
    logic [NUM_INPUTS-1:0]  sh_mask;
    logic [LAG_WIDTH:0]     lag_next, lag_end;
    logic                   kill, sweep_end;

    assign kill       = abort | ~enable;
    assign frame_load = (frame_cycles == '0) ? '0 : frame_cycles - FRAME_WIDTH'(1);
    // One extra bit so the end-of-sweep compare cannot wrap.
    assign lag_next   = {1'b0, cur_lag} + (LAG_WIDTH+1)'(sh_inc);
    assign lag_end    = {1'b0, sh_start} + {1'b0, sh_len};
    assign sweep_end  = (sh_inc == '0) || (lag_next >= lag_end);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start && enable && !abort) state_nxt = LOAD;
            LOAD:      state_nxt = INTEGRATE;
            INTEGRATE: if (frame_cnt == '0) state_nxt = TX_WAIT;
            TX_WAIT:   if (tx_ack) state_nxt = STEP;
            STEP:      state_nxt = sweep_end ? DONE : INTEGRATE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        if (state != IDLE && kill) state_nxt = IDLE;
    end

    // Strobes are registered from the next state so they align with the state.
    always_ff @(posedge intclk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            integrate     <= 1'b0;
            capture_start <= 1'b0;
            tx_req        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nxt;
            integrate     <= (state_nxt == INTEGRATE);
            capture_start <= (state_nxt == INTEGRATE) && (state != INTEGRATE);
            tx_req        <= (state_nxt == TX_WAIT);
            busy          <= (state_nxt != IDLE);
            done          <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge intclk or posedge reset) begin
        if (reset) begin
            frame_init    <= '0;
            frame_cnt     <= '0;
            sh_start      <= '0;
            sh_len        <= '0;
            sh_inc        <= '0;
            sh_mask       <= '0;
            cur_lag       <= '0;
            frame_idx     <= '0;
            lag_current_a <= '0;
        end else if (!kill) begin
            case (state)
                LOAD: begin
                    frame_init <= frame_load;
                    frame_cnt  <= frame_load;
                    sh_start   <= lag_start;
                    sh_len     <= lag_len;
                    sh_inc     <= lag_inc;
                    sh_mask    <= chan_mask;
                    cur_lag    <= lag_start;
                    frame_idx  <= '0;
                    for (int unsigned a = 0; a < NUM_INPUTS; a++)
                        lag_current_a[a*LAG_WIDTH +: LAG_WIDTH] <= lag_start;
                end
                INTEGRATE: begin
                    if (frame_cnt != '0) frame_cnt <= frame_cnt - FRAME_WIDTH'(1);
                end
                STEP: begin
                    if (!sweep_end) begin
                        cur_lag   <= lag_next[LAG_WIDTH-1:0];
                        frame_cnt <= frame_init;
                        if (frame_idx != '1) frame_idx <= frame_idx + IDX_WIDTH'(1);
                        for (int unsigned a = 0; a < NUM_INPUTS; a++)
                            if (sh_mask[a])
                                lag_current_a[a*LAG_WIDTH +: LAG_WIDTH] <= lag_next[LAG_WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lag_sweep_sequencer.sv
// Directed self-checking bench for lag_sweep_sequencer.
module tb_lag_sweep_sequencer;

    localparam int unsigned N  = 8;
    localparam int unsigned LW = 20;
    localparam int unsigned IW = 12;
    localparam int unsigned FW = 24;
    localparam int unsigned XW = 12;

    logic          intclk = 1'b0;
    logic          reset, enable, start, abort, tx_ack;
    logic [FW-1:0] frame_cycles;
    logic [LW-1:0] lag_start, lag_len;
    logic [IW-1:0] lag_inc;
    logic [N-1:0]  chan_mask;
    logic          integrate, capture_start, tx_req, busy, done;
    logic [N*LW-1:0] lag_current_a;
    logic [XW-1:0] frame_idx;

    int checks = 0;
    int failures = 0;

    lag_sweep_sequencer #(
        .NUM_INPUTS(N), .LAG_WIDTH(LW), .INC_WIDTH(IW), .FRAME_WIDTH(FW), .IDX_WIDTH(XW)
    ) dut (
        .intclk(intclk), .reset(reset), .enable(enable), .start(start), .abort(abort),
        .frame_cycles(frame_cycles), .lag_start(lag_start), .lag_len(lag_len),
        .lag_inc(lag_inc), .chan_mask(chan_mask), .tx_ack(tx_ack),
        .integrate(integrate), .capture_start(capture_start), .tx_req(tx_req),
        .busy(busy), .done(done), .lag_current_a(lag_current_a), .frame_idx(frame_idx)
    );

    always #5 intclk = ~intclk;

    // Per-sweep observations gathered by observe()
    int          obs_cycles, obs_done, obs_min_gap, obs_bad_change, obs_overlap;
    bit          obs_timeout;
    int          obs_len[$];
    int          obs_txc[$];
    logic [N*LW-1:0] obs_lag[$];
    logic [XW-1:0]   obs_idx[$];

    function automatic logic [N*LW-1:0] lanes(input logic [LW-1:0] on, input logic [LW-1:0] off,
                                              input logic [N-1:0] m);
        logic [N*LW-1:0] v;
        v = '0;
        for (int unsigned a = 0; a < N; a++) v[a*LW +: LW] = m[a] ? on : off;
        return v;
    endfunction

    task automatic tick();
        @(posedge intclk);
        #1;
    endtask

    task automatic start_sweep(input logic [FW-1:0] fc, input logic [LW-1:0] ls, input logic [LW-1:0] ll,
                               input logic [IW-1:0] li, input logic [N-1:0] m);
        frame_cycles = fc; lag_start = ls; lag_len = ll; lag_inc = li; chan_mask = m;
        enable = 1'b1; abort = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic observe(input int ack_delay, input int budget);
        int len, tr, gap;
        logic [N*LW-1:0] prev;
        len = 0; tr = 0; gap = 0;
        obs_len.delete(); obs_txc.delete(); obs_lag.delete(); obs_idx.delete();
        obs_cycles = 0; obs_done = 0; obs_min_gap = 1 << 30; obs_bad_change = 0; obs_overlap = 0;
        obs_timeout = 1'b1;
        prev = lag_current_a;
        for (int c = 1; c <= budget; c++) begin
            tick();
            if (lag_current_a !== prev && !capture_start) obs_bad_change++;
            prev = lag_current_a;
            if (capture_start) begin
                if (obs_lag.size() > 0 && gap < obs_min_gap) obs_min_gap = gap;
                obs_lag.push_back(lag_current_a);
                obs_idx.push_back(frame_idx);
            end
            if (integrate) begin
                len++; gap = 0;
            end else begin
                if (len > 0) obs_len.push_back(len);
                len = 0; gap++;
            end
            if (integrate && tx_req) obs_overlap++;
            if (tx_req) begin
                tr++; tx_ack = (tr >= ack_delay);
            end else begin
                if (tr > 0) obs_txc.push_back(tr);
                tr = 0; tx_ack = 1'b0;
            end
            if (done) obs_done++;
            if (!busy) begin
                obs_cycles = c; obs_timeout = 1'b0;
                break;
            end
        end
        tx_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; start = 1'b0; abort = 1'b0; tx_ack = 1'b0;
        frame_cycles = '0; lag_start = '0; lag_len = '0; lag_inc = '0; chan_mask = '0;
        repeat (2) tick();
        checks++;
        if ({integrate, capture_start, tx_req, busy, done} !== 5'b0 || lag_current_a !== '0 || frame_idx !== '0) begin
            failures++;
            $display("FAIL reset_values strobes=%b lag=%h idx=%0d required all zero",
                     {integrate, capture_start, tx_req, busy, done}, lag_current_a, frame_idx);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        start_sweep(4, 10, 30, 10, 8'hFF);
        checks++;
        if (busy !== 1'b1 || integrate !== 1'b0) begin
            failures++; $display("FAIL basic_load busy=%b integrate=%b required busy=1 integrate=0", busy, integrate);
        end
        observe(1, 100);
        checks++; if (obs_timeout) begin failures++; $display("FAIL basic_timeout sweep did not finish within 100 cycles"); end
        checks++; if (obs_lag.size() != 3) begin failures++; $display("FAIL basic_frames got=%0d required=3", obs_lag.size()); end
        for (int i = 0; i < 3 && i < obs_lag.size(); i++) begin
            checks++;
            if (obs_lag[i] !== lanes(LW'(10 + 10*i), 10, 8'hFF)) begin
                failures++; $display("FAIL basic_lag[%0d] got=%h required=%h", i, obs_lag[i], lanes(LW'(10 + 10*i), 10, 8'hFF));
            end
            checks++;
            if (obs_idx[i] !== XW'(i)) begin failures++; $display("FAIL basic_idx[%0d] got=%0d required=%0d", i, obs_idx[i], i); end
        end
        for (int i = 0; i < 3 && i < obs_len.size(); i++) begin
            checks++; if (obs_len[i] != 4) begin failures++; $display("FAIL basic_len[%0d] got=%0d required=4", i, obs_len[i]); end
        end
        checks++; if (obs_done != 1) begin failures++; $display("FAIL basic_done got=%0d required=1", obs_done); end
        checks++; if (obs_cycles != 20) begin failures++; $display("FAIL basic_cycles got=%0d required=20", obs_cycles); end
        checks++; if (obs_min_gap != 2) begin failures++; $display("FAIL basic_gap got=%0d required=2", obs_min_gap); end
        checks++; if (obs_bad_change != 0) begin failures++; $display("FAIL basic_lag_stable changes=%0d required=0", obs_bad_change); end
        checks++;
        if (lag_current_a !== lanes(30, 30, 8'hFF) || frame_idx !== XW'(2)) begin
            failures++; $display("FAIL basic_hold lag=%h idx=%0d required lag=30 idx=2", lag_current_a, frame_idx);
        end
    endtask

    task automatic test_edge_spans();
        start_sweep(3, 50, 0, 5, 8'hFF);
        observe(1, 50);
        checks++;
        if (obs_timeout || obs_lag.size() != 1 || obs_done != 1) begin
            failures++; $display("FAIL len0_frames got=%0d done=%0d required frames=1 done=1", obs_lag.size(), obs_done);
        end else begin
            checks++; if (obs_lag[0] !== lanes(50, 50, 8'hFF)) begin failures++; $display("FAIL len0_lag got=%h required=50s", obs_lag[0]); end
            checks++; if (obs_len[0] != 3) begin failures++; $display("FAIL len0_len got=%0d required=3", obs_len[0]); end
        end

        start_sweep(2, 7, 100, 0, 8'hFF);
        observe(1, 50);
        checks++;
        if (obs_timeout || obs_lag.size() != 1 || obs_done != 1) begin
            failures++; $display("FAIL inc0_frames got=%0d done=%0d required frames=1 done=1", obs_lag.size(), obs_done);
        end else begin
            checks++; if (obs_lag[0] !== lanes(7, 7, 8'hFF)) begin failures++; $display("FAIL inc0_lag got=%h required=7s", obs_lag[0]); end
        end

        start_sweep(0, 0, 3, 1, 8'hFF);
        observe(1, 50);
        checks++;
        if (obs_timeout || obs_lag.size() != 3 || obs_len.size() != 3) begin
            failures++; $display("FAIL fc0_frames got=%0d lens=%0d required=3", obs_lag.size(), obs_len.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_len[i] != 1 || obs_lag[i] !== lanes(LW'(i), 0, 8'hFF)) begin
                    failures++; $display("FAIL fc0_frame[%0d] len=%0d lag=%h required len=1 lag=%0d", i, obs_len[i], obs_lag[i], i);
                end
            end
        end
        checks++; if (obs_cycles != 11) begin failures++; $display("FAIL fc0_cycles got=%0d required=11", obs_cycles); end
    endtask

    task automatic test_back_pressure();
        start_sweep(2, 100, 20, 10, 8'hFF);
        observe(5, 100);
        checks++;
        if (obs_timeout || obs_lag.size() != 2 || obs_txc.size() != 2) begin
            failures++; $display("FAIL bp_frames got=%0d tx=%0d required=2", obs_lag.size(), obs_txc.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_txc[i] != 5) begin failures++; $display("FAIL bp_txreq[%0d] got=%0d required=5", i, obs_txc[i]); end
                checks++;
                if (obs_lag[i] !== lanes(LW'(100 + 10*i), 100, 8'hFF)) begin
                    failures++; $display("FAIL bp_lag[%0d] got=%h required=%0d", i, obs_lag[i], 100 + 10*i);
                end
            end
        end
        checks++; if (obs_overlap != 0) begin failures++; $display("FAIL bp_overlap got=%0d required=0", obs_overlap); end
        checks++; if (obs_bad_change != 0) begin failures++; $display("FAIL bp_lag_stable got=%0d required=0", obs_bad_change); end
        checks++; if (obs_min_gap != 6) begin failures++; $display("FAIL bp_gap got=%0d required=6", obs_min_gap); end
        checks++; if (obs_cycles != 18) begin failures++; $display("FAIL bp_cycles got=%0d required=18", obs_cycles); end
    endtask

    task automatic test_mask();
        start_sweep(1, 0, 6, 3, 8'b0000_0101);
        observe(1, 50);
        checks++;
        if (obs_timeout || obs_lag.size() != 2) begin
            failures++; $display("FAIL mask_frames got=%0d required=2", obs_lag.size());
        end else begin
            checks++; if (obs_lag[0] !== '0) begin failures++; $display("FAIL mask_lag0 got=%h required=0", obs_lag[0]); end
            checks++;
            if (obs_lag[1] !== lanes(3, 0, 8'b0000_0101)) begin
                failures++; $display("FAIL mask_lag1 got=%h required=%h", obs_lag[1], lanes(3, 0, 8'b0000_0101));
            end
        end
    endtask

    task automatic test_abort();
        bit seen_done;
        start_sweep(4, 10, 30, 10, 8'hFF);
        tick();
        start = 1'b1; lag_start = 999;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || integrate !== 1'b1 || capture_start !== 1'b0 || lag_current_a !== lanes(10, 10, 8'hFF)) begin
            failures++; $display("FAIL start_ignored busy=%b int=%b cap=%b lag=%h required 1,1,0,10s",
                                 busy, integrate, capture_start, lag_current_a);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || integrate !== 1'b0 || tx_req !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL abort_idle busy=%b int=%b tx=%b done=%b required 0000", busy, integrate, tx_req, done);
        end
        checks++; if (lag_current_a !== lanes(10, 10, 8'hFF)) begin failures++; $display("FAIL abort_lag_hold got=%h required=10s", lag_current_a); end
        seen_done = 1'b0;
        repeat (3) begin tick(); if (done || busy) seen_done = 1'b1; end
        checks++; if (seen_done) begin failures++; $display("FAIL abort_no_done activity after abort required none"); end

        start_sweep(4, 10, 30, 10, 8'hFF);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        checks++;
        if (busy !== 1'b0 || integrate !== 1'b0) begin
            failures++; $display("FAIL enable_abort busy=%b int=%b required 0,0", busy, integrate);
        end
    endtask

    task automatic test_reset_midsweep();
        bit found;
        found = 1'b0;
        tx_ack = 1'b0;
        start_sweep(2, 40, 20, 10, 8'hFF);
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (tx_req) found = 1'b1;
        end
        checks++; if (!found) begin failures++; $display("FAIL rst_reach_txwait tx_req=0 required=1 within 20 cycles"); end
        reset = 1'b1;
        #1;
        checks++;
        if ({integrate, capture_start, tx_req, busy, done} !== 5'b0 || lag_current_a !== '0 || frame_idx !== '0) begin
            failures++; $display("FAIL rst_async strobes=%b lag=%h idx=%0d required all zero",
                                 {integrate, capture_start, tx_req, busy, done}, lag_current_a, frame_idx);
        end
        #2;
        reset = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_idle busy=%b required=0", busy); end
        start_sweep(2, 40, 20, 10, 8'hFF);
        observe(1, 50);
        checks++;
        if (obs_timeout || obs_lag.size() != 2 || obs_done != 1) begin
            failures++; $display("FAIL rst_clean_frames got=%0d done=%0d required frames=2 done=1", obs_lag.size(), obs_done);
        end else begin
            checks++;
            if (obs_lag[1] !== lanes(50, 40, 8'hFF) || obs_idx[1] !== XW'(1)) begin
                failures++; $display("FAIL rst_clean_lag got=%h idx=%0d required lag=50 idx=1", obs_lag[1], obs_idx[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edge_spans();
        test_back_pressure();
        test_mask();
        test_abort();
        test_reset_midsweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
